// File: rtl/gen_monitor.sv
// rtl/gen_monitor.sv - Game of Life generation monitor: population, generation count, still/osc2/extinct flags
module gen_monitor #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16,
  localparam int NROWS  = 1 << REGBITS,
  localparam int POPW   = REGBITS + $clog2(WIDTH) + 1
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               clear,
  input  logic               row_valid,
  input  logic [REGBITS-1:0] row_addr,
  input  logic [WIDTH-1:0]   row_data,
  output logic [POPW-1:0]    population,
  output logic [GENBITS-1:0] gen_count,
  output logic               extinct,
  output logic               still,
  output logic               osc2,
  output logic               status_valid,
  output logic               seq_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2
  } state_t;

  state_t                        state;
  logic [REGBITS-1:0]            exp_row;
  logic [POPW-1:0]               acc;
  logic [1:0]                    hist;
  logic [NROWS-1:0][WIDTH-1:0]   cur;
  logic [NROWS-1:0][WIDTH-1:0]   prev1;
  logic [NROWS-1:0][WIDTH-1:0]   prev2;

  logic [POPW-1:0]               row_pop;
  logic                          last_row;

  function automatic logic [POPW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POPW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + POPW'(v[i]);
    end
    return n;
  endfunction

  assign row_pop  = popcount(row_data);
  assign last_row = (row_addr == REGBITS'(NROWS - 1));

  // Row sequencing, shadow-board capture and end-of-generation evaluation
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      exp_row      <= '0;
      acc          <= '0;
      hist         <= '0;
      cur          <= '0;
      prev1        <= '0;
      prev2        <= '0;
      population   <= '0;
      gen_count    <= '0;
      extinct      <= 1'b0;
      still        <= 1'b0;
      osc2         <= 1'b0;
      status_valid <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      if (clear) begin
        // Board history is left in place; hist = 0 makes it irrelevant.
        state      <= IDLE;
        exp_row    <= '0;
        acc        <= '0;
        hist       <= '0;
        population <= '0;
        gen_count  <= '0;
        extinct    <= 1'b0;
        still      <= 1'b0;
        osc2       <= 1'b0;
        seq_err    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (row_valid) begin
              if (row_addr == '0) begin
                cur[row_addr] <= row_data;
                acc           <= row_pop;
                exp_row       <= REGBITS'(1);
                state         <= last_row ? EVAL : ACCUM;
              end else begin
                seq_err <= 1'b1;
              end
            end
          end
          ACCUM: begin
            if (row_valid) begin
              if (row_addr == '0) begin
                // An early row 0 is a restart, not an error.
                cur[row_addr] <= row_data;
                acc           <= row_pop;
                exp_row       <= REGBITS'(1);
                state         <= last_row ? EVAL : ACCUM;
              end else if (row_addr == exp_row) begin
                cur[row_addr] <= row_data;
                acc           <= acc + row_pop;
                exp_row       <= exp_row + REGBITS'(1);
                if (last_row) begin
                  state <= EVAL;
                end
              end else begin
                seq_err <= 1'b1;
                acc     <= '0;
                exp_row <= '0;
                state   <= IDLE;
              end
            end
          end
          EVAL: begin
            if (row_valid) begin
              seq_err <= 1'b1;
            end
            population   <= acc;
            extinct      <= (acc == '0);
            still        <= (hist != 2'd0) && (cur == prev1);
            osc2         <= (hist == 2'd2) && (cur == prev2) && (cur != prev1);
            prev2        <= prev1;
            prev1        <= cur;
            hist         <= (hist == 2'd2) ? 2'd2 : hist + 2'd1;
            if (gen_count != '1) begin
              gen_count <= gen_count + GENBITS'(1);
            end
            status_valid <= 1'b1;
            exp_row      <= '0;
            state        <= IDLE;
          end
          default: begin
            state   <= IDLE;
            exp_row <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gen_monitor.sv
// tb/tb_gen_monitor.sv - directed self-checking bench for gen_monitor
module tb_gen_monitor;

  logic        ph1;
  logic        reset;
  logic        clear;
  logic        row_valid;
  logic [2:0]  row_addr;
  logic [7:0]  row_data;
  logic [6:0]  population;
  logic [15:0] gen_count;
  logic        extinct;
  logic        still;
  logic        osc2;
  logic        status_valid;
  logic        seq_err;

  logic [6:0]  population2;
  logic [1:0]  gen_count2;
  logic        extinct2;
  logic        still2;
  logic        osc22;
  logic        status_valid2;
  logic        seq_err2;

  int checks;
  int errors;
  int sv_count;

  gen_monitor #(.WIDTH(8), .REGBITS(3), .GENBITS(16)) dut (
    .ph1(ph1), .reset(reset), .clear(clear), .row_valid(row_valid),
    .row_addr(row_addr), .row_data(row_data), .population(population),
    .gen_count(gen_count), .extinct(extinct), .still(still), .osc2(osc2),
    .status_valid(status_valid), .seq_err(seq_err)
  );

  gen_monitor #(.WIDTH(8), .REGBITS(3), .GENBITS(2)) dut2 (
    .ph1(ph1), .reset(reset), .clear(clear), .row_valid(row_valid),
    .row_addr(row_addr), .row_data(row_data), .population(population2),
    .gen_count(gen_count2), .extinct(extinct2), .still(still2), .osc2(osc22),
    .status_valid(status_valid2), .seq_err(seq_err2)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  // Count status pulses away from the active edge
  always @(negedge ph1) begin
    if (status_valid) sv_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_row(input logic [2:0] a, input logic [7:0] d, input logic clr);
    @(negedge ph1);
    row_valid = 1'b1;
    row_addr  = a;
    row_data  = d;
    clear     = clr;
    @(posedge ph1);
    #1;
    row_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge ph1);
    clear = 1'b1;
    @(posedge ph1);
    #1;
    clear = 1'b0;
  endtask

  task automatic run_gen(input string tag, input logic [63:0] b, input logic [6:0] pop,
                         input logic ext, input logic st, input logic osc, input logic [15:0] gen);
    for (int i = 0; i < 8; i++) send_row(i[2:0], b[i*8 +: 8], 1'b0);
    check({tag, "_sv_early"}, 32'(status_valid), 32'd0);
    @(posedge ph1);
    #1;
    check({tag, "_sv"}, 32'(status_valid), 32'd1);
    check({tag, "_pop"}, 32'(population), 32'(pop));
    check({tag, "_extinct"}, 32'(extinct), 32'(ext));
    check({tag, "_still"}, 32'(still), 32'(st));
    check({tag, "_osc2"}, 32'(osc2), 32'(osc));
    check({tag, "_gen"}, 32'(gen_count), 32'(gen));
    @(posedge ph1);
    #1;
    check({tag, "_sv_drop"}, 32'(status_valid), 32'd0);
  endtask

  localparam logic [63:0] EMPTY   = 64'h0;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000; // rows 3,4 = 0x18
  localparam logic [63:0] BLINK_A = 64'h0000_0008_0808_0000; // rows 2,3,4 = 0x08
  localparam logic [63:0] BLINK_B = 64'h0000_0000_1C00_0000; // row 3 = 0x1C

  int sv_before;

  initial begin
    checks    = 0;
    errors    = 0;
    sv_count  = 0;
    reset     = 1'b0;
    clear     = 1'b0;
    row_valid = 1'b0;
    row_addr  = '0;
    row_data  = '0;
    repeat (2) @(posedge ph1);
    #1;
    check("rst_pop", 32'(population), 32'd0);
    check("rst_gen", 32'(gen_count), 32'd0);
    check("rst_flags", 32'({extinct, still, osc2, status_valid, seq_err}), 32'd0);
    @(negedge ph1);
    reset = 1'b1;

    // Empty board
    run_gen("empty", EMPTY, 7'd0, 1'b1, 1'b0, 1'b0, 16'd1);

    // Block still life
    do_clear();
    check("clr_gen", 32'(gen_count), 32'd0);
    check("clr_extinct", 32'(extinct), 32'd0);
    run_gen("block1", BLOCK, 7'd4, 1'b0, 1'b0, 1'b0, 16'd1);
    run_gen("block2", BLOCK, 7'd4, 1'b0, 1'b1, 1'b0, 16'd2);

    // Blinker A, B, A
    do_clear();
    run_gen("blinkA1", BLINK_A, 7'd3, 1'b0, 1'b0, 1'b0, 16'd1);
    run_gen("blinkB",  BLINK_B, 7'd3, 1'b0, 1'b0, 1'b0, 16'd2);
    run_gen("blinkA2", BLINK_A, 7'd3, 1'b0, 1'b0, 1'b1, 16'd3);

    // Sequence error: rows 0,1,3
    do_clear();
    sv_before = sv_count;
    send_row(3'd0, 8'h00, 1'b0);
    send_row(3'd1, 8'h00, 1'b0);
    check("seq_pre", 32'(seq_err), 32'd0);
    send_row(3'd3, 8'h00, 1'b0);
    check("seq_set", 32'(seq_err), 32'd1);
    repeat (4) @(posedge ph1);
    #1;
    check("seq_no_sv", 32'(sv_count - sv_before), 32'd0);
    run_gen("seq_clean", BLOCK, 7'd4, 1'b0, 1'b0, 1'b0, 16'd1);
    check("seq_sticky", 32'(seq_err), 32'd1);

    // Asynchronous reset mid-generation
    for (int i = 0; i < 5; i++) send_row(i[2:0], 8'hFF, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_pop", 32'(population), 32'd0);
    check("arst_gen", 32'(gen_count), 32'd0);
    check("arst_flags", 32'({extinct, still, osc2, status_valid, seq_err}), 32'd0);
    @(negedge ph1);
    reset = 1'b1;
    run_gen("post_rst", BLOCK, 7'd4, 1'b0, 1'b0, 1'b0, 16'd1);

    // clear coincident with row 7
    send_row(3'd5, 8'h00, 1'b0);
    check("idle_err", 32'(seq_err), 32'd1);
    sv_before = sv_count;
    for (int i = 0; i < 7; i++) send_row(i[2:0], 8'h00, 1'b0);
    send_row(3'd7, 8'h00, 1'b1);
    repeat (3) @(posedge ph1);
    #1;
    check("clr7_no_sv", 32'(sv_count - sv_before), 32'd0);
    check("clr7_gen", 32'(gen_count), 32'd0);
    check("clr7_seq", 32'(seq_err), 32'd0);
    check("clr7_pop", 32'(population), 32'd0);

    // Saturation of a 2-bit counter over five generations
    run_gen("sat1", EMPTY, 7'd0, 1'b1, 1'b0, 1'b0, 16'd1);
    run_gen("sat2", EMPTY, 7'd0, 1'b1, 1'b1, 1'b0, 16'd2);
    run_gen("sat3", EMPTY, 7'd0, 1'b1, 1'b1, 1'b0, 16'd3);
    check("sat_g2_3", 32'(gen_count2), 32'd3);
    run_gen("sat4", EMPTY, 7'd0, 1'b1, 1'b1, 1'b0, 16'd4);
    run_gen("sat5", EMPTY, 7'd0, 1'b1, 1'b1, 1'b0, 16'd5);
    check("sat_g2_5", 32'(gen_count2), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
